// File: rtl/ddr_arb_pkg.sv
// Shared types and widths for the DDR read arbiter and its round-robin picker.
package ddr_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_IDLE,
    DONE
  } state_t;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 32;

endpackage

// File: rtl/ddr_rd_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Kept standalone so the write-side arbiter can reuse it.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        gnt_idx = cand;
        found   = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read engine among N_REQ requesters, one transaction at a time.
// Optional per-requester performance counters are built when DDR_RD_ARB_PERF_EN is defined.
module ddr_rd_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int START_TO = 16,
  localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*LEN_W-1:0]  req_len,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        req_done,
  output logic                    RSTART_REG,
  output logic [ADDR_W-1:0]       RADDR_REG,
  output logic [LEN_W-1:0]        RLENGTH_REG,
  input  logic                    RIDLE_REG,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy
`ifdef DDR_RD_ARB_PERF_EN
  ,
  input  logic                    perf_clr,
  output logic [N_REQ*32-1:0]     perf_txn,
  output logic [N_REQ*32-1:0]     perf_cyc
`endif
);

  localparam int CNT_W = $clog2(START_TO + 1);

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [LEN_W-1:0]  len_arr  [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign addr_arr[gi] = req_addr[ADDR_W*gi +: ADDR_W];
    assign len_arr[gi]  = req_len[LEN_W*gi +: LEN_W];
  end

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              rstart_q, rstart_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    ready_d    = '0;
    done_d     = '0;
    rstart_d   = 1'b0;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        // Holding off until the engine is idle keeps starts from ever overlapping.
        if (RIDLE_REG && pick_any) begin
          ready_d    = N_REQ'(1) << pick_idx;
          addr_d     = addr_arr[pick_idx];
          len_d      = len_arr[pick_idx];
          grant_id_d = pick_idx;
          ptr_d      = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
          state_d    = (len_arr[pick_idx] == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        rstart_d = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A short job may finish before RIDLE is ever seen low; the timeout covers that.
        if (!RIDLE_REG) begin
          state_d = WAIT_IDLE;
        end else if (cnt_q == CNT_W'(START_TO - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_IDLE: begin
        if (RIDLE_REG) state_d = DONE;
      end
      DONE: begin
        done_d  = N_REQ'(1) << grant_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      ready_q    <= '0;
      done_q     <= '0;
      rstart_q   <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      rstart_q   <= rstart_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign req_ready   = ready_q;
  assign req_done    = done_q;
  assign RSTART_REG  = rstart_q;
  assign RADDR_REG   = addr_q;
  assign RLENGTH_REG = len_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;

`ifdef DDR_RD_ARB_PERF_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf
    logic [31:0] txn_q, txn_d;
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
      txn_d = txn_q;
      cyc_d = cyc_q;
      if (perf_clr) begin
        txn_d = '0;
        cyc_d = '0;
      end else begin
        if (done_q[gi]) txn_d = txn_q + 32'd1;
        if (busy_q && (grant_id_q == IDX_W'(gi))) cyc_d = cyc_q + 32'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        txn_q <= '0;
        cyc_q <= '0;
      end else begin
        txn_q <= txn_d;
        cyc_q <= cyc_d;
      end
    end

    assign perf_txn[32*gi +: 32] = txn_q;
    assign perf_cyc[32*gi +: 32] = cyc_q;
  end
`endif

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Bench for ddr_rd_arbiter: directed scenarios plus random traffic against a transaction-level model
// and a simple read-engine responder. Counter checks are compiled in when DDR_RD_ARB_PERF_EN is defined.
module tb_ddr_rd_arbiter;

  localparam int N        = 4;
  localparam int START_TO = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_addr;
  logic [N*32-1:0] req_len;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_done;
  logic            RSTART_REG;
  logic [31:0]     RADDR_REG;
  logic [31:0]     RLENGTH_REG;
  logic            RIDLE_REG;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef DDR_RD_ARB_PERF_EN
  logic            perf_clr;
  logic [N*32-1:0] perf_txn;
  logic [N*32-1:0] perf_cyc;
`endif

  always #5 clk = ~clk;

  ddr_rd_arbiter #(.N_REQ(N), .START_TO(START_TO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .RSTART_REG  (RSTART_REG),
    .RADDR_REG   (RADDR_REG),
    .RLENGTH_REG (RLENGTH_REG),
    .RIDLE_REG   (RIDLE_REG),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef DDR_RD_ARB_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .perf_txn    (perf_txn),
    .perf_cyc    (perf_cyc)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
  } job_t;

  job_t jq [N][$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // transaction-level model state
  bit          t_act = 0;
  int          t_g, t_ready, t_done, t_hold;
  bit          t_ign;
  logic [31:0] t_addr, t_len;
  int          ptr_m = 0;
  int          gid_m = 0;
  bit          idle_prev = 1;
  logic [N-1:0] valid_prev;
  bit          ridle_prev;
  bit          rstn_prev;

  // engine responder
  int  eng_hold = 3;
  bit  eng_ignore = 0;
  bit  eng_force = 0;
  bit  eng_force_val = 1;
  bit  eng_act = 0;
  bit  eng_ign_cur = 0;
  int  eng_t = 0;
  int  eng_hold_cur = 0;
  bit  ridle_drv = 1;
  assign RIDLE_REG = ridle_drv;

  // observations
  int  last_rs = -100;
  int  last_rdy = -100;
  int  last_done = -100;
  bit  low_seen = 1;
  bit  chk_rdl = 0;
  int  n_rstart = 0;
  int  gseq_obs[$];

  // counter model
  logic [31:0]  ptxn_m [N];
  logic [31:0]  pcyc_m [N];
  bit           busy_prev_m = 0;
  int           gid_prev_m = 0;
  logic [N-1:0] done_prev_m = '0;
  bit           pclr_prev = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int rr_ref(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (jq[i].size() > 0) return 1'b1;
    return t_act;
  endfunction

  task automatic load(input int i);
    if (jq[i].size() > 0) begin
      req_valid[i]         = 1'b1;
      req_addr[32*i +: 32] = jq[i][0].addr;
      req_len[32*i +: 32]  = jq[i][0].len;
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic push(input int i, input logic [31:0] a, input logic [31:0] l);
    job_t j;
    j.addr = a;
    j.len  = l;
    jq[i].push_back(j);
    if (!req_valid[i]) load(i);
  endtask

  task automatic tick();
    logic [N-1:0] rdy_exp;
    logic [N-1:0] done_exp;
    bit           rs_exp;
    bit           busy_exp;
    int           g;
    valid_prev = req_valid;
    ridle_prev = ridle_drv;
    rstn_prev  = rstn;
`ifdef DDR_RD_ARB_PERF_EN
    pclr_prev  = perf_clr;
`endif
    @(negedge clk);
    cyc++;
    if (!rstn_prev) begin
      check("rst_ctrl", {req_ready, req_done, RSTART_REG, busy, grant_id}, 64'd0);
      check("rst_addr_len", {RADDR_REG, RLENGTH_REG}, 64'd0);
      t_act = 0; ptr_m = 0; gid_m = 0; idle_prev = 1; low_seen = 1; last_rs = -100;
      busy_prev_m = 0; done_prev_m = '0;
      for (int i = 0; i < N; i++) begin
        ptxn_m[i] = '0;
        pcyc_m[i] = '0;
`ifdef DDR_RD_ARB_PERF_EN
        check("rst_perf", {perf_txn[32*i +: 32], perf_cyc[32*i +: 32]}, 64'd0);
`endif
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (pclr_prev) begin
          ptxn_m[i] = '0;
          pcyc_m[i] = '0;
        end else begin
          if (done_prev_m[i]) ptxn_m[i] = ptxn_m[i] + 32'd1;
          if (busy_prev_m && gid_prev_m == i) pcyc_m[i] = pcyc_m[i] + 32'd1;
        end
`ifdef DDR_RD_ARB_PERF_EN
        check("perf_txn", perf_txn[32*i +: 32], ptxn_m[i]);
        check("perf_cyc", perf_cyc[32*i +: 32], pcyc_m[i]);
`endif
      end
      rdy_exp = '0;
      g = rr_ref(valid_prev, ptr_m);
      if (idle_prev && ridle_prev && g >= 0) rdy_exp = {{(N-1){1'b0}}, 1'b1} << g;
      check("req_ready", req_ready, rdy_exp);
      if (req_ready != '0) begin
        gseq_obs.push_back(int'(grant_id));
        last_rdy = cyc;
      end
      if (rdy_exp != '0) begin
        t_act   = 1;
        t_g     = g;
        t_ready = cyc;
        t_addr  = jq[g][0].addr;
        t_len   = jq[g][0].len;
        t_hold  = eng_hold;
        t_ign   = eng_ignore;
        t_done  = (t_len == 0) ? cyc + 1 : (t_ign ? cyc + 2 + START_TO : cyc + 5 + t_hold);
        ptr_m   = (g + 1) % N;
        gid_m   = g;
        void'(jq[g].pop_front());
        load(g);
      end
      check("grant_id", grant_id, gid_m);
      rs_exp = t_act && (t_len != 0) && (cyc == t_ready + 1);
      check("rstart", RSTART_REG, rs_exp);
      if (rs_exp) begin
        check("raddr", RADDR_REG, t_addr);
        check("rlength", RLENGTH_REG, t_len);
      end
      if (RSTART_REG) begin
        n_rstart++;
        if (chk_rdl) check("ridle_cycled", low_seen, 1);
        check("rstart_gap", (cyc - last_rs) >= 4, 1);
        last_rs      = cyc;
        low_seen     = 0;
        eng_act      = 1;
        eng_t        = -1;
        eng_hold_cur = t_act ? t_hold : eng_hold;
        eng_ign_cur  = t_act ? t_ign : eng_ignore;
      end
      done_exp = (t_act && cyc == t_done) ? ({{(N-1){1'b0}}, 1'b1} << t_g) : '0;
      check("req_done", req_done, done_exp);
      if (req_done != '0) last_done = cyc;
      busy_exp = t_act && (cyc < t_done);
      check("busy", busy, busy_exp);
      busy_prev_m = busy_exp;
      gid_prev_m  = gid_m;
      done_prev_m = done_exp;
      idle_prev   = !busy_exp;
      if (done_exp != '0) begin
        $display("txn req%0d addr=%08h len=%0d accept@%0d done@%0d", t_g, t_addr, t_len, t_ready, cyc);
        t_act = 0;
      end
    end
    // engine: RIDLE low from 2 cycles after RSTART for eng_hold_cur cycles
    if (eng_act) begin
      eng_t++;
      if (eng_t >= 2 + eng_hold_cur) eng_act = 0;
    end
    ridle_drv = eng_force ? eng_force_val : !(eng_act && !eng_ign_cur && eng_t >= 2);
    if (!ridle_drv) low_seen = 1;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (pending() && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout cyc=%0d observed=pending expected=idle", cyc);
    end
    repeat (2) tick();
  endtask

  initial begin
    int n0;
    int k;
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    rstn      = 1'b0;
`ifdef DDR_RD_ARB_PERF_EN
    perf_clr  = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      ptxn_m[i] = '0;
      pcyc_m[i] = '0;
    end
    repeat (3) tick();
    rstn = 1'b1;
    repeat (2) tick();

    // single request, engine busy for 10 cycles
    eng_hold = 10;
    n0 = n_rstart;
    push(0, 32'h0000_1000, 32'd8);
    drain(200);
    check("t1_rstart_count", n_rstart - n0, 1);
    check("t1_rstart_latency", last_rs - last_rdy, 1);
    check("t1_done_latency", last_done - last_rdy, 15);

    // all four requesters continuously valid, three jobs each, from ptr 0
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    tick();
    eng_hold = 3;
    chk_rdl  = 1;
    gseq_obs.delete();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) push(i, $urandom, $urandom_range(1, 64));
    end
    drain(1000);
    chk_rdl = 0;
    check("t2_grant_count", gseq_obs.size(), 12);
    for (int j = 0; j < 12 && j < gseq_obs.size(); j++) check("t2_grant_order", gseq_obs[j], j % N);

    // zero-length request: ready then done, no engine start
    n0 = n_rstart;
    push(2, 32'hABCD_0000, 32'd0);
    drain(100);
    check("t3_no_rstart", n_rstart - n0, 0);
    check("t3_done_latency", last_done - last_rdy, 1);

    // engine ignores RSTART: completion forced by timeout, next grant proceeds
    eng_ignore = 1;
    push(3, 32'h0000_3000, 32'd20);
    drain(200);
    check("t4_timeout", last_done - last_rs, START_TO + 1);
    eng_ignore = 0;
    n0 = n_rstart;
    push(0, 32'h0000_4000, 32'd4);
    drain(200);
    check("t4_next_grant", n_rstart - n0, 1);

    // reset while waiting for the engine to go idle
    eng_hold = 30;
    push(1, 32'h0000_5000, 32'd16);
    k = 0;
    while (!(t_act && t_len != 0 && cyc >= t_ready + 5) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL t5_reach_wait_idle cyc=%0d observed=not_reached expected=reached", cyc);
    end
    check("t5_ridle_low", RIDLE_REG, 0);
    push(2, 32'h0000_6000, 32'd4);
    push(3, 32'h0000_7000, 32'd4);
    eng_force     = 1;
    eng_force_val = 0;
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    gseq_obs.delete();
    repeat (4) tick();
    check("t5_no_grant_while_busy", gseq_obs.size(), 0);
    eng_force = 0;
    eng_act   = 0;
    ridle_drv = 1;
    eng_hold  = 3;
    drain(300);
    check("t5_grant_count", gseq_obs.size(), 2);
    if (gseq_obs.size() >= 2) begin
      check("t5_first_grant", gseq_obs[0], 2);
      check("t5_second_grant", gseq_obs[1], 3);
    end

`ifdef DDR_RD_ARB_PERF_EN
    // counters: two 12-cycle transactions on requester 1, then clear
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    eng_hold = 7;
    push(1, 32'h0000_8000, 32'd9);
    push(1, 32'h0000_9000, 32'd10);
    drain(200);
    check("t6_perf_txn1", perf_txn[63:32], 2);
    check("t6_perf_cyc1", perf_cyc[63:32], 24);
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    check("t6_clr_txn1", perf_txn[63:32], 0);
    check("t6_clr_cyc1", perf_cyc[63:32], 0);
    tick();
`endif

    // random traffic
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        push(int'($urandom_range(0, N - 1)), $urandom,
             ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      end
      eng_hold = int'($urandom_range(1, 8));
      tick();
    end
    drain(5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
